// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer and its 1-bit slice:
// ctrl/comp code constants, slice operation encodings, the sequencer state
// type and a helper that turns a ctrl opcode into slice control settings.
package alu_pkg;

   // ctrl_i opcodes
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_NOR = 4'b1100;
   localparam logic [3:0] ALU_CMP = 4'b0111;

   // comp_i codes (110/111 are the unsigned compares when enabled)
   localparam logic [2:0] CMP_LT  = 3'b000;
   localparam logic [2:0] CMP_GT  = 3'b001;
   localparam logic [2:0] CMP_LE  = 3'b010;
   localparam logic [2:0] CMP_GE  = 3'b011;
   localparam logic [2:0] CMP_EQ  = 3'b100;
   localparam logic [2:0] CMP_NE  = 3'b101;
   localparam logic [2:0] CMP_ULT = 3'b110;
   localparam logic [2:0] CMP_UGE = 3'b111;

   // Slice operation select
   localparam logic [1:0] SLICE_AND  = 2'b00;
   localparam logic [1:0] SLICE_OR   = 2'b01;
   localparam logic [1:0] SLICE_ADD  = 2'b10;
   localparam logic [1:0] SLICE_COMP = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      CMP  = 2'b10,
      DONE = 2'b11
   } state_e;

   // Per-op slice settings used throughout the RUN phase
   typedef struct packed {
      logic [1:0] operation;
      logic       a_invert;
      logic       b_invert;
      logic       cin0;     // carry-in applied at bit 0
      logic       arith;    // op produces meaningful cout/overflow
      logic       is_cmp;   // op continues into the CMP cycle
   } slice_ctrl_t;

   // Unknown opcodes fall back to plain AND
   function automatic slice_ctrl_t decode_ctrl(input logic [3:0] ctrl);
      slice_ctrl_t c;
      c = '{operation: SLICE_AND, a_invert: 1'b0, b_invert: 1'b0,
            cin0: 1'b0, arith: 1'b0, is_cmp: 1'b0};
      case (ctrl)
         ALU_OR: c.operation = SLICE_OR;
         ALU_ADD: begin
            c.operation = SLICE_ADD;
            c.arith     = 1'b1;
         end
         ALU_SUB: begin
            c.operation = SLICE_ADD;
            c.b_invert  = 1'b1;
            c.cin0      = 1'b1;
            c.arith     = 1'b1;
         end
         ALU_CMP: begin
            c.operation = SLICE_ADD;
            c.b_invert  = 1'b1;
            c.cin0      = 1'b1;
            c.arith     = 1'b1;
            c.is_cmp    = 1'b1;
         end
         ALU_NOR: begin
            c.a_invert  = 1'b1;
            c.b_invert  = 1'b1;
         end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/alu_top.sv
// One-bit ALU slice: optional input inversion, AND/OR/full-add, and a
// compare mode that turns the less/equal flags into a 0/1 answer per comp.
module alu_top
   import alu_pkg::*;
(
   input  logic       src1,
   input  logic       src2,
   input  logic       less,
   input  logic       equal,
   input  logic [2:0] comp,
   input  logic       A_invert,
   input  logic       B_invert,
   input  logic       cin,
   input  logic [1:0] operation,
   output logic       result,
   output logic       cout
);

   logic a_bit;
   logic b_bit;
   logic cmp_bit;

   // Operand conditioning, full adder and compare decode
   always_comb begin
      a_bit = src1 ^ A_invert;
      b_bit = src2 ^ B_invert;
      cout  = (a_bit & b_bit) | (a_bit & cin) | (b_bit & cin);
      case (comp)
         CMP_LT:  cmp_bit = less;
         CMP_GT:  cmp_bit = ~less & ~equal;
         CMP_LE:  cmp_bit = less | equal;
         CMP_GE:  cmp_bit = ~less;
         CMP_EQ:  cmp_bit = equal;
         CMP_NE:  cmp_bit = ~equal;
         default: cmp_bit = 1'b0;
      endcase
   end

   // Output select
   always_comb begin
      case (operation)
         SLICE_AND:  result = a_bit & b_bit;
         SLICE_OR:   result = a_bit | b_bit;
         SLICE_ADD:  result = a_bit ^ b_bit ^ cin;
         default:    result = cmp_bit;
      endcase
   end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: feeds one alu_top slice one bit per cycle,
// LSB first, and assembles the WIDTH-bit result plus carry/overflow/zero.
// Handshake: start_i is taken only in IDLE; busy_o is high from the cycle
// after accept until the result is ready; done_o pulses for one cycle with
// result_o/zero_o/cout_o/overflow_o valid, and those outputs hold until the
// next result is produced.
// Build option: SERIAL_ALU_UNSIGNED_CMP_EN enables comp codes 110/111 as
// unsigned < and unsigned >=; without it those codes yield 0.
module serial_alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [3:0]       ctrl_i,
   input  logic [2:0]       comp_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             cout_o,
   output logic             overflow_o
);

   localparam int            KW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [3:0]       ctrl_q, ctrl_d;
   logic [2:0]       comp_q, comp_d;
   logic             cin_q, cin_d;
   logic             cin_msb_q, cin_msb_d;
   logic             cout_msb_q, cout_msb_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   slice_ctrl_t dec;
   logic        sub_ovf;
   logic        s_src1, s_src2, s_less, s_equal;
   logic [2:0]  s_comp;
   logic        s_ainv, s_binv, s_cin;
   logic [1:0]  s_op;
   logic        s_result, s_cout;

   alu_top u_slice (
      .src1      (s_src1),
      .src2      (s_src2),
      .less      (s_less),
      .equal     (s_equal),
      .comp      (s_comp),
      .A_invert  (s_ainv),
      .B_invert  (s_binv),
      .cin       (s_cin),
      .operation (s_op),
      .result    (s_result),
      .cout      (s_cout)
   );

   // Slice drive, derived only from registered state
   always_comb begin
      dec     = decode_ctrl(ctrl_q);
      sub_ovf = cin_msb_q ^ cout_msb_q;
      s_src1  = 1'b0;
      s_src2  = 1'b0;
      s_less  = 1'b0;
      s_equal = 1'b0;
      s_comp  = comp_q;
      s_ainv  = 1'b0;
      s_binv  = 1'b0;
      s_cin   = 1'b0;
      s_op    = SLICE_AND;
      case (state_q)
         RUN: begin
            s_src1 = a_q[k_q];
            s_src2 = b_q[k_q];
            s_op   = dec.operation;
            s_ainv = dec.a_invert;
            s_binv = dec.b_invert;
            s_cin  = (k_q == '0) ? dec.cin0 : cin_q;
         end
         CMP: begin
            // res_q holds A-B; signed less accounts for overflow
            s_op    = SLICE_COMP;
            s_less  = res_q[WIDTH-1] ^ sub_ovf;
            s_equal = (res_q == '0);
`ifdef SERIAL_ALU_UNSIGNED_CMP_EN
            if (comp_q == CMP_ULT) begin
               s_less = ~cout_msb_q;
               s_comp = CMP_LT;
            end else if (comp_q == CMP_UGE) begin
               s_less = ~cout_msb_q;
               s_comp = CMP_GE;
            end
`endif
         end
         default: ;
      endcase
   end

   // Next-state, counter, shift register and output registers
   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      a_d        = a_q;
      b_d        = b_q;
      ctrl_d     = ctrl_q;
      comp_d     = comp_q;
      cin_d      = cin_q;
      cin_msb_d  = cin_msb_q;
      cout_msb_d = cout_msb_q;
      res_d      = res_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      result_d   = result_q;
      zero_d     = zero_q;
      cout_d     = cout_q;
      ovf_d      = ovf_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               a_d     = src1_i;
               b_d     = src2_i;
               ctrl_d  = ctrl_i;
               comp_d  = comp_i;
               res_d   = '0;
               k_d     = '0;
               cin_d   = 1'b0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            // New bit enters at the MSB so bit k settles at position k
            res_d = {s_result, res_q[WIDTH-1:1]};
            cin_d = s_cout;
            k_d   = k_q + 1'b1;
            if (k_q == K_LAST) begin
               k_d        = '0;
               cin_msb_d  = s_cin;
               cout_msb_d = s_cout;
               if (dec.is_cmp) begin
                  state_d = CMP;
               end else begin
                  state_d  = DONE;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
                  result_d = res_d;
                  zero_d   = (res_d == '0);
                  cout_d   = dec.arith & s_cout;
                  ovf_d    = dec.arith & (s_cin ^ s_cout);
               end
            end
         end
         CMP: begin
            state_d  = DONE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            result_d = {{(WIDTH-1){1'b0}}, s_result};
            zero_d   = ~s_result;
            cout_d   = cout_msb_q;
            ovf_d    = sub_ovf;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         k_q        <= '0;
         a_q        <= '0;
         b_q        <= '0;
         ctrl_q     <= '0;
         comp_q     <= '0;
         cin_q      <= 1'b0;
         cin_msb_q  <= 1'b0;
         cout_msb_q <= 1'b0;
         res_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         result_q   <= '0;
         zero_q     <= 1'b0;
         cout_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         a_q        <= a_d;
         b_q        <= b_d;
         ctrl_q     <= ctrl_d;
         comp_q     <= comp_d;
         cin_q      <= cin_d;
         cin_msb_q  <= cin_msb_d;
         cout_msb_q <= cout_msb_d;
         res_q      <= res_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         result_q   <= result_d;
         zero_q     <= zero_d;
         cout_q     <= cout_d;
         ovf_q      <= ovf_d;
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign result_o   = result_q;
   assign zero_o     = zero_q;
   assign cout_o     = cout_q;
   assign overflow_o = ovf_q;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Bench for serial_alu_seq (WIDTH=32): directed cases, random operations
// scored against an arithmetic reference model, start/reset corner cases.
module tb_serial_alu_seq;

   localparam int W  = 32;
   localparam int EW = W + 3 + 8; // {latency, ovf, cout, zero, result}

   logic         clk_i;
   logic         rst_i;
   logic         start_i;
   logic [3:0]   ctrl_i;
   logic [2:0]   comp_i;
   logic [W-1:0] src1_i;
   logic [W-1:0] src2_i;
   logic         busy_o;
   logic         done_o;
   logic [W-1:0] result_o;
   logic         zero_o;
   logic         cout_o;
   logic         overflow_o;

   serial_alu_seq #(.WIDTH(W)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .start_i    (start_i),
      .ctrl_i     (ctrl_i),
      .comp_i     (comp_i),
      .src1_i     (src1_i),
      .src2_i     (src2_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .result_o   (result_o),
      .zero_o     (zero_o),
      .cout_o     (cout_o),
      .overflow_o (overflow_o)
   );

   // ---------------- clock / cycle count ----------------
   int cyc;
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end
   initial cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [EW-1:0] exp_q[$];
   int            acc_q[$];
   int            checks;
   int            failures;
   int            done_cnt;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [EW-1:0] model(input logic [3:0] c, input logic [2:0] cp,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
      longint       sa, sb, ua, ub, ssum;
      logic [W-1:0] r;
      logic         co, ov;
      logic [7:0]   lat;
      sa  = $signed(a);
      sb  = $signed(b);
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      co  = 1'b0;
      ov  = 1'b0;
      lat = 8'(W);
      case (c)
         4'b0001: r = a | b;
         4'b1100: r = ~(a | b);
         4'b0010: begin
            r    = a + b;
            co   = (ua + ub) > 64'hFFFF_FFFF;
            ssum = sa + sb;
            ov   = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
         end
         4'b0110, 4'b0111: begin
            r    = a - b;
            co   = (ua >= ub);
            ssum = sa - sb;
            ov   = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
            if (c == 4'b0111) begin
               lat = 8'(W + 1);
               case (cp)
                  3'd0: r = W'(sa <  sb);
                  3'd1: r = W'(sa >  sb);
                  3'd2: r = W'(sa <= sb);
                  3'd3: r = W'(sa >= sb);
                  3'd4: r = W'(a == b);
                  3'd5: r = W'(a != b);
`ifdef SERIAL_ALU_UNSIGNED_CMP_EN
                  3'd6: r = W'(ua <  ub);
                  3'd7: r = W'(ua >= ub);
`endif
                  default: r = '0;
               endcase
            end
         end
         default: r = a & b;
      endcase
      return {lat, ov, co, (r == '0), r};
   endfunction

   // ---------------- monitor ----------------
   logic [EW-1:0] mon_e;
   int            mon_acc;
   always @(negedge clk_i) begin
      if (!rst_i && done_o) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
         end else begin
            mon_e   = exp_q.pop_front();
            mon_acc = acc_q.pop_front();
            check("result",   64'(result_o),   64'(mon_e[W-1:0]));
            check("zero",     64'(zero_o),     64'(mon_e[W]));
            check("cout",     64'(cout_o),     64'(mon_e[W+1]));
            check("overflow", 64'(overflow_o), 64'(mon_e[W+2]));
            check("latency",  64'(cyc - mon_acc), 64'(mon_e[EW-1:W+3]));
            check("busy_at_done", 64'(busy_o), 64'd0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic rand_inputs();
      ctrl_i = 4'($urandom);
      comp_i = 3'($urandom);
      src1_i = $urandom;
      src2_i = $urandom;
   endtask

   // Returns at a negedge with the DUT idle (not busy, no done pulse)
   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while ((busy_o || done_o) && n < 200);
      if (n >= 200) begin
         checks++;
         failures++;
         $display("FAIL wait_idle_timeout actual=busy required=idle (t=%0t)", $time);
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done_o && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      if (!done_o) begin
         checks++;
         failures++;
         $display("FAIL wait_done_timeout actual=0 required=1 (t=%0t)", $time);
      end
   endtask

   task automatic issue(input logic [3:0] c, input logic [2:0] cp,
                        input logic [W-1:0] a, input logic [W-1:0] b);
      wait_idle();
      ctrl_i  = c;
      comp_i  = cp;
      src1_i  = a;
      src2_i  = b;
      start_i = 1'b1;
      exp_q.push_back(model(c, cp, a, b));
      acc_q.push_back(cyc + 1);
      @(negedge clk_i);
      start_i = 1'b0;
      rand_inputs();
   endtask

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // ---------------- main sequence ----------------
   logic [3:0] op_tab [8];
   int         t0;
   int         done_before;
   logic [W-1:0] ra, rb;

   initial begin
      op_tab[0] = 4'b0000; op_tab[1] = 4'b0001; op_tab[2] = 4'b0010; op_tab[3] = 4'b0110;
      op_tab[4] = 4'b1100; op_tab[5] = 4'b0111; op_tab[6] = 4'b0011; op_tab[7] = 4'b1111;
      checks   = 0;
      failures = 0;
      done_cnt = 0;
      rst_i    = 1'b1;
      start_i  = 1'b0;
      rand_inputs();
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      check("rst_busy",   64'(busy_o),     64'd0);
      check("rst_done",   64'(done_o),     64'd0);
      check("rst_result", 64'(result_o),   64'd0);
      check("rst_zero",   64'(zero_o),     64'd0);
      check("rst_cout",   64'(cout_o),     64'd0);
      check("rst_ovf",    64'(overflow_o), 64'd0);

      // Directed cases
      issue(4'b0010, 3'd0, 32'h7FFF_FFFF, 32'h0000_0001);
      issue(4'b0110, 3'd0, 32'd5, 32'd5);
      issue(4'b1100, 3'd0, 32'h0F0F_0000, 32'h0000_0F0F);
      issue(4'b0111, 3'd0, 32'hFFFF_FFFD, 32'd2);
      issue(4'b0111, 3'd1, 32'hFFFF_FFFD, 32'd2);
      issue(4'b0111, 3'd4, 32'd7, 32'd7);
      issue(4'b0111, 3'd6, 32'd1, 32'hFFFF_FFFF);
      issue(4'b0111, 3'd7, 32'd1, 32'hFFFF_FFFF);
      issue(4'b0111, 3'd0, 32'h8000_0000, 32'd1);
      issue(4'b0010, 3'd0, 32'hFFFF_FFFF, 32'd1);

      // start_i held through part of the run, then a stray pulse mid-run
      wait_idle();
      done_before = done_cnt;
      ctrl_i = 4'b0010; comp_i = 3'd0; src1_i = 32'h1234_5678; src2_i = 32'h1111_1111;
      start_i = 1'b1;
      exp_q.push_back(model(4'b0010, 3'd0, 32'h1234_5678, 32'h1111_1111));
      acc_q.push_back(cyc + 1);
      t0 = cyc + 1;
      repeat (6) begin
         @(negedge clk_i);
         rand_inputs();
      end
      start_i = 1'b0;
      while (cyc < t0 + 10) @(negedge clk_i);
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk_i);
      check("single_done_held_start", 64'(done_cnt - done_before), 64'd1);

      // start_i raised during the done cycle: taken one cycle later in IDLE
      issue(4'b0110, 3'd0, 32'd3, 32'd10);
      wait_done();
      ra = $urandom; rb = $urandom;
      ctrl_i = 4'b0001; comp_i = 3'd0; src1_i = ra; src2_i = rb;
      start_i = 1'b1;
      exp_q.push_back(model(4'b0001, 3'd0, ra, rb));
      acc_q.push_back(cyc + 2);
      @(negedge clk_i);
      @(negedge clk_i);
      start_i = 1'b0;
      rand_inputs();

      // Reset in the middle of an ADD aborts it with no done pulse
      issue(4'b0010, 3'd0, 32'hDEAD_BEEF, 32'h0101_0101);
      repeat (14) @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      exp_q.delete();
      acc_q.delete();
      rst_i = 1'b0;
      check("abort_busy",   64'(busy_o),     64'd0);
      check("abort_done",   64'(done_o),     64'd0);
      check("abort_result", 64'(result_o),   64'd0);
      check("abort_zero",   64'(zero_o),     64'd0);
      check("abort_cout",   64'(cout_o),     64'd0);
      check("abort_ovf",    64'(overflow_o), 64'd0);
      done_before = done_cnt;
      repeat (40) @(negedge clk_i);
      check("abort_no_done", 64'(done_cnt - done_before), 64'd0);
      issue(4'b0010, 3'd0, 32'd100, 32'd23);

      // Randomised operations
      for (int i = 0; i < 50; i++) begin
         ra = pick_operand();
         rb = ($urandom_range(0, 5) == 0) ? ra : pick_operand();
         issue(op_tab[$urandom_range(0, 7)], 3'($urandom_range(0, 7)), ra, rb);
      end

      wait_idle();
      repeat (3) @(negedge clk_i);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
